// File: rtl/serial_to_parallel.sv
// LSB-first framed serial receiver: start bit, N data bits, optional even parity.
// Define SERIAL_TO_PARALLEL_PARITY_EN to expect and check a parity bit after the data.
module serial_to_parallel #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         EN,
    input  logic         SIN,
    output logic [N-1:0] DATAR,
    output logic         VALID,
    input  logic         ACK,
    output logic         BUSY,
    output logic         OVERRUN,
    output logic         PERR
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam logic [1:0] PAR  = 2'd2;
    // The full word must survive into the parity state, so keep all N bits.
    localparam int SR_LSB = 0;
`else
    // Bit 0 of the register would be shifted out on the completing edge unread.
    localparam int SR_LSB = 1;
`endif

    logic [1:0]        state_q, state_d;
    logic [N-1:SR_LSB] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      datar_q, datar_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              perr_q, perr_d;

    logic [N-1:0]      shifted_word;
    logic [N-1:0]      done_word;
    logic              complete;

    assign shifted_word = {SIN, sr_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        datar_d   = datar_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = 1'b0;
        complete  = 1'b0;
        done_word = shifted_word;

        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (SIN) begin
                        state_d = RECV;
                        cnt_d   = '0;
                    end
                end
                RECV: begin
                    sr_d  = shifted_word[N-1:SR_LSB];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                        state_d = PAR;
`else
                        state_d  = IDLE;
                        complete = 1'b1;
`endif
                    end
                end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                PAR: begin
                    state_d   = IDLE;
                    done_word = sr_q;
                    if ((^sr_q) ^ SIN) begin
                        perr_d = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // A finishing word wins over a plain ACK; ACK on that edge makes room for it.
        if (complete) begin
            if (!valid_q || ACK) begin
                datar_d   = done_word;
                valid_d   = 1'b1;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ACK) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            datar_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            datar_q   <= datar_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign DATAR   = datar_q;
    assign VALID   = valid_q;
    assign BUSY    = busy_q;
    assign OVERRUN = overrun_q;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    assign PERR    = perr_q;
`else
    assign PERR    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (N=8): a vector table for one frame plus
// hand-written sequences for gaps, overrun, ACK races, back-to-back frames and reset.
module tb_serial_to_parallel;

    logic       CLK;
    logic       N_RESET;
    logic       EN;
    logic       SIN;
    logic       ACK;
    logic [7:0] DATAR;
    logic       VALID;
    logic       BUSY;
    logic       OVERRUN;
    logic       PERR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       sin;
        logic       ack;
        logic [7:0] datar;
        logic       valid;
        logic       busy;
        logic       overrun;
    } vec_t;

    vec_t vecs[$];

    serial_to_parallel #(.N(8)) dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .EN      (EN),
        .SIN     (SIN),
        .DATAR   (DATAR),
        .VALID   (VALID),
        .ACK     (ACK),
        .BUSY    (BUSY),
        .OVERRUN (OVERRUN),
        .PERR    (PERR)
    );

    // Free-running 10-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one edge's worth of inputs, then sample 1 unit after the edge.
    task automatic applyStimulus(input logic en, input logic sin, input logic ack);
        EN  = en;
        SIN = sin;
        ACK = ack;
        @(posedge CLK);
        #1;
        EN  = 1'b0;
        SIN = 1'b0;
        ACK = 1'b0;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expDatar,
                               input logic expValid, input logic expBusy,
                               input logic expOverrun, input logic expPerr);
        checks++;
        if (DATAR !== expDatar) begin
            errors++;
            $display("[TB] FAIL %s.DATAR: got %h expected %h", name, DATAR, expDatar);
        end
        checkBit({name, ".VALID"}, VALID, expValid);
        checkBit({name, ".BUSY"}, BUSY, expBusy);
        checkBit({name, ".OVERRUN"}, OVERRUN, expOverrun);
        checkBit({name, ".PERR"}, PERR, expPerr);
    endtask

    task automatic idleGaps(input int gaps, input logic noise);
        for (int g = 0; g < gaps; g++) begin
            applyStimulus(1'b0, noise, 1'b0);
            checkBit("gap_busy", BUSY, 1'b1);
        end
    endtask

    // Send one whole frame; ackLast asserts ACK on the edge that ends the frame.
    task automatic sendFrame(input logic [7:0] data, input int gaps,
                             input logic ackLast, input logic badPar);
        logic isLast;
        applyStimulus(1'b1, 1'b1, 1'b0);
        idleGaps(gaps, 1'b0);
        for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            isLast = 1'b0;
`else
            isLast = (i == 7);
`endif
            if (isLast) checkBit("busy_before_last", BUSY, 1'b1);
            applyStimulus(1'b1, data[i], isLast ? ackLast : 1'b0);
            if (!isLast) idleGaps(gaps, ~data[i]);
        end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        checkBit("busy_before_parity", BUSY, 1'b1);
        applyStimulus(1'b1, (^data) ^ badPar, ackLast);
`else
        if (badPar) $display("[TB] note: parity request ignored in this build");
`endif
    endtask

    task automatic pulseReset();
        #2;
        N_RESET = 1'b0;
        #1;
        checkOutput("in_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        N_RESET = 1'b1;
    endtask

    initial begin
        N_RESET = 1'b0;
        EN      = 1'b0;
        SIN     = 1'b0;
        ACK     = 1'b0;
        #3;
        checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        N_RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Frame 0xA5 with EN held high; idle zero and disabled start bit first.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0});
`else
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0});
`endif
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].sin, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].datar, vecs[i].valid,
                        vecs[i].busy, vecs[i].overrun, 1'b0);
        end

        // Same frame with three disabled edges after every bit.
        pulseReset();
        sendFrame(8'hA5, 3, 1'b0, 1'b0);
        checkOutput("gapped_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Overrun: unacknowledged word blocks the next one.
        applyStimulus(1'b0, 1'b0, 1'b1);
        sendFrame(8'h3C, 0, 1'b0, 1'b0);
        checkOutput("first_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(8'hC3, 0, 1'b0, 1'b0);
        checkOutput("dropped_c3", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ack_clears", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

        // ACK on the completion edge lets the new word in.
        sendFrame(8'h11, 0, 1'b0, 1'b0);
        checkOutput("hold_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h22, 0, 1'b1, 1'b0);
        checkOutput("race_22", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h33, 0, 1'b0, 1'b0);
        checkOutput("dropped_33", 8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h44, 0, 1'b1, 1'b0);
        checkOutput("race_44_clears_ovr", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);

        // ACK with nothing pending is ignored.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ack_idle", 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with no idle edge between them.
        sendFrame(8'h5A, 0, 1'b0, 1'b0);
        checkOutput("b2b_first", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h96, 0, 1'b1, 1'b0);
        checkOutput("b2b_second", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame, then a clean frame.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkBit("mid_frame_busy", BUSY, 1'b1);
        pulseReset();
        sendFrame(8'h7E, 0, 1'b0, 1'b0);
        checkOutput("after_reset_7e", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        // Parity failure drops the word and pulses PERR for one cycle.
        applyStimulus(1'b0, 1'b0, 1'b1);
        sendFrame(8'hA5, 0, 1'b0, 1'b1);
        checkOutput("bad_parity", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("perr_one_cycle", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
        sendFrame(8'hA5, 0, 1'b0, 1'b0);
        checkOutput("good_parity", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Receive-side partner of the parallel-to-serial shifter. Consumes a framed, LSB-first serial bit stream, one bit per enabled clock, and assembles N-bit words. Presents each word on a held parallel output with a VALID/ACK handshake. Flags overruns when a new word completes before the previous one is acknowledged.

Parameters:
N, 8, data word width in bits; legal range N >= 2.

Ports:
CLK  input  1  system clock, rising-edge active
N_RESET  input  1  asynchronous, active-low reset
EN  input  1  bit strobe; SIN sampled and FSM advances only on edges where EN=1
SIN  input  1  serial data in; idle level 0
DATAR  output  N  received word; stable while VALID=1
VALID  output  1  DATAR holds an unacknowledged word
ACK  input  1  consumer acknowledge; effective only while VALID=1
BUSY  output  1  frame reception in progress (state RECV or PAR)
OVERRUN  output  1  sticky flag: a completed word was dropped
PERR  output  1  one-cycle pulse: parity failure, word dropped (see Optional Feature)

Behaviour:
- Reset (async, N_RESET=0): state IDLE; shift reg, bit counter, DATAR = 0; VALID, BUSY, OVERRUN, PERR = 0. Reset overrides all other inputs, including mid-frame; a partial frame is discarded.
- Frame format: start bit 1, then N data bits LSB first, then an optional parity bit.
- Edges with EN=0: FSM, shift reg and counter hold. The ACK path still operates.
- FSM:
  - IDLE: EN=1 & SIN=1 -> RECV, counter=0. EN=1 & SIN=0 -> stay IDLE.
  - RECV: each EN=1 edge shifts right: sr <= {SIN, sr[N-1:1]}, counter++.
  - RECV, edge sampling the Nth data bit (counter==N-1): without parity, word completes and FSM -> IDLE; with parity, FSM -> PAR.
  - PAR: EN=1 samples the parity bit, completes or rejects the word, then -> IDLE.
- Counter width: $clog2(N). Never wraps within a frame.
- Completion edge: the assembled word is {SIN, sr[N-1:1]}.
  - If VALID=0, or VALID=1 and ACK=1 on the same edge: DATAR <= word, VALID <= 1.
  - Otherwise DATAR and VALID hold, word dropped, OVERRUN <= 1.
- Latency: DATAR/VALID updated on the same edge that samples the final frame bit.
- ACK: VALID=1 & ACK=1 & no completion on that edge -> VALID <= 0, OVERRUN <= 0. ACK with VALID=0 is ignored.
- Simultaneous completion + ACK: the new word is loaded, VALID stays 1, OVERRUN clears.
- Back-to-back frames: IDLE accepts a start bit on the EN edge immediately after completion; no gap is required.
- BUSY = (state != IDLE), registered with the state.
- DATAR only changes at reset or on a successful load.

Optional Feature:
Macro: SERIAL_TO_PARALLEL_PARITY_EN
- Defined: PAR state present. The frame carries one even-parity bit after the data, so XOR of data and parity = 0.
  - Mismatch: word dropped, DATAR/VALID/OVERRUN unaffected, PERR=1 for exactly one cycle following that edge.
  - Match: completion rules above apply.
- Undefined: no PAR state; frame is start + N data bits; PERR is tied to 0. The port list is identical in both builds.

Test Plan:
- N=8, EN=1 continuously, SIN = 1,1,0,1,0,0,1,0,1 (start, then 0xA5 LSB first) -> after the final bit DATAR=0xA5, VALID=1, BUSY=0, OVERRUN=0.
- Same frame with EN=0 inserted for 3 cycles between every bit -> identical DATAR=0xA5; state and counter frozen during the gaps.
- Receive 0x3C without ACK, then frame 0xC3 -> DATAR stays 0x3C, OVERRUN=1. Then ACK -> VALID=0, OVERRUN=0.
- VALID=1 holding 0x11, ACK asserted on the completion edge of frame 0x22 -> DATAR=0x22, VALID=1, OVERRUN=0.
- Pulse N_RESET low after 4 data bits, then send a full frame 0x7E -> outputs 0 during reset; the next frame gives DATAR=0x7E, with no residue from the aborted frame.
- PARITY_EN build: frame 0xA5 with parity bit 0 -> VALID=1. Frame 0xA5 with parity bit 1 -> PERR one-cycle pulse, VALID and DATAR unchanged.
